// File: rtl/exc_ctrl.sv
// MEM-stage exception controller: arbitrates MEM exception flags against
// Status/Cause interrupts (with WB bypass) and issues flush plus CP0 commit.
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'h00000020,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_valid_i,
    input  logic [31:0]      mem_pc_i,
    input  logic             mem_in_dslot_i,
    input  logic [4:0]       exc_flags_i,
    input  logic [31:0]      cp0_status_i,
    input  logic [31:0]      cp0_cause_i,
    input  logic [31:0]      cp0_epc_i,
    input  logic             wb_cp0_we_i,
    input  logic [4:0]       wb_cp0_waddr_i,
    input  logic [31:0]      wb_cp0_wdata_i,
    output logic             flush_o,
    output logic [31:0]      new_pc_o,
    output logic             exc_we_o,
    output logic [4:0]       exc_code_o,
    output logic [31:0]      exc_epc_o,
    output logic             exc_bd_o,
    output logic             eret_o,
    output logic [CNT_W-1:0] exc_cnt_o
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_FLUSH = 1'b1;

    localparam logic [4:0] CODE_INT  = 5'd0;
    localparam logic [4:0] CODE_SYS  = 5'd8;
    localparam logic [4:0] CODE_RI   = 5'd10;
    localparam logic [4:0] CODE_OV   = 5'd12;
    localparam logic [4:0] CODE_TRAP = 5'd13;

    localparam logic [4:0] ADDR_STATUS = 5'd12;
    localparam logic [4:0] ADDR_CAUSE  = 5'd13;
    localparam logic [4:0] ADDR_EPC    = 5'd14;

    localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

    logic [0:0]       state_q, state_d;
    logic [2:0]       fcnt_q, fcnt_d;
    logic [31:0]      new_pc_q, new_pc_d;
    logic             we_q, we_d;
    logic             eret_q, eret_d;
    logic [4:0]       code_q, code_d;
    logic [31:0]      epc_q, epc_d;
    logic             bd_q, bd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0] status_eff;
    logic [31:0] cause_eff;
    logic [31:0] epc_eff;
    logic        int_pend;
    logic        take_exc;
    logic        take_eret;
    logic [4:0]  det_code;

    // A CP0 write still sitting in WB must be seen as if already committed.
    always_comb begin
        status_eff = cp0_status_i;
        cause_eff  = cp0_cause_i;
        epc_eff    = cp0_epc_i;
        if (wb_cp0_we_i) begin
            case (wb_cp0_waddr_i)
                ADDR_STATUS: status_eff = wb_cp0_wdata_i;
                ADDR_CAUSE:  cause_eff[9:8] = wb_cp0_wdata_i[9:8];
                ADDR_EPC:    epc_eff = wb_cp0_wdata_i;
                default:     ;
            endcase
        end
    end

    assign int_pend = status_eff[0] & ~status_eff[1]
                    & (|(cause_eff[15:8] & status_eff[15:8]));

    always_comb begin
        take_exc  = 1'b0;
        take_eret = 1'b0;
        det_code  = CODE_INT;
        if (state_q == S_IDLE && mem_valid_i) begin
            if (int_pend) begin
                take_exc = 1'b1;
                det_code = CODE_INT;
            end else if (exc_flags_i[0]) begin
                take_exc = 1'b1;
                det_code = CODE_SYS;
            end else if (exc_flags_i[1]) begin
                take_exc = 1'b1;
                det_code = CODE_RI;
            end else if (exc_flags_i[2]) begin
                take_exc = 1'b1;
                det_code = CODE_OV;
            end else if (exc_flags_i[3]) begin
                take_exc = 1'b1;
                det_code = CODE_TRAP;
            end else if (exc_flags_i[4]) begin
                take_eret = 1'b1;
            end
        end
    end

    // Commit values hold between events; only the pulses return to zero.
    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        new_pc_d = new_pc_q;
        we_d     = 1'b0;
        eret_d   = 1'b0;
        code_d   = code_q;
        epc_d    = epc_q;
        bd_d     = bd_q;
        cnt_d    = cnt_q;
        if (state_q == S_IDLE) begin
            if (take_exc || take_eret) begin
                state_d = S_FLUSH;
                fcnt_d  = FLUSH_LAST;
                cnt_d   = cnt_q + 1'b1;
            end
            if (take_exc) begin
                new_pc_d = EXC_VECTOR;
                we_d     = 1'b1;
                code_d   = det_code;
                epc_d    = mem_in_dslot_i ? (mem_pc_i - 32'd4) : mem_pc_i;
                bd_d     = mem_in_dslot_i;
            end else if (take_eret) begin
                new_pc_d = epc_eff;
                eret_d   = 1'b1;
            end
        end else begin
            if (fcnt_q == 3'd0) begin
                state_d = S_IDLE;
            end else begin
                fcnt_d = fcnt_q - 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            fcnt_q   <= 3'd0;
            new_pc_q <= 32'd0;
            we_q     <= 1'b0;
            eret_q   <= 1'b0;
            code_q   <= 5'd0;
            epc_q    <= 32'd0;
            bd_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            new_pc_q <= new_pc_d;
            we_q     <= we_d;
            eret_q   <= eret_d;
            code_q   <= code_d;
            epc_q    <= epc_d;
            bd_q     <= bd_d;
            cnt_q    <= cnt_d;
        end
    end

    assign flush_o    = (state_q == S_FLUSH);
    assign new_pc_o   = new_pc_q;
    assign exc_we_o   = we_q;
    assign eret_o     = eret_q;
    assign exc_code_o = code_q;
    assign exc_epc_o  = epc_q;
    assign exc_bd_o   = bd_q;
    assign exc_cnt_o  = cnt_q;

    logic unused_bits;
    assign unused_bits = ^{cause_eff[31:16], cause_eff[7:0],
                           status_eff[31:16], status_eff[7:2]};

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: two instances (1- and 3-cycle flush) driven with the same
// directed and random stimulus, checked against a behavioural model.
module tb_exc_ctrl;

    localparam int NI = 2;
    localparam int FC [NI] = '{1, 3};
    localparam int CW [NI] = '{16, 4};
    localparam logic [31:0] VEC = 32'h00000020;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic        dslot;
    logic [4:0]  flags;
    logic [31:0] status, cause, epc;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_wd;

    logic        flush_a, we_a, bd_a, eret_a;
    logic [31:0] pc_a, epc_a;
    logic [4:0]  code_a;
    logic [15:0] cnt_a;
    logic        flush_b, we_b, bd_b, eret_b;
    logic [31:0] pc_b, epc_b;
    logic [4:0]  code_b;
    logic [3:0]  cnt_b;

    int n_tests = 0;
    int n_fail  = 0;

    // model state, per instance
    int          m_left [NI];
    logic [31:0] m_pc   [NI];
    logic        m_we   [NI];
    logic        m_eret [NI];
    logic [4:0]  m_code [NI];
    logic [31:0] m_epc  [NI];
    logic        m_bd   [NI];
    int          m_cnt  [NI];

    exc_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .mem_valid_i(mem_valid), .mem_pc_i(mem_pc),
        .mem_in_dslot_i(dslot), .exc_flags_i(flags), .cp0_status_i(status),
        .cp0_cause_i(cause), .cp0_epc_i(epc), .wb_cp0_we_i(wb_we),
        .wb_cp0_waddr_i(wb_addr), .wb_cp0_wdata_i(wb_wd),
        .flush_o(flush_a), .new_pc_o(pc_a), .exc_we_o(we_a), .exc_code_o(code_a),
        .exc_epc_o(epc_a), .exc_bd_o(bd_a), .eret_o(eret_a), .exc_cnt_o(cnt_a)
    );

    exc_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(3), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .mem_valid_i(mem_valid), .mem_pc_i(mem_pc),
        .mem_in_dslot_i(dslot), .exc_flags_i(flags), .cp0_status_i(status),
        .cp0_cause_i(cause), .cp0_epc_i(epc), .wb_cp0_we_i(wb_we),
        .wb_cp0_waddr_i(wb_addr), .wb_cp0_wdata_i(wb_wd),
        .flush_o(flush_b), .new_pc_o(pc_b), .exc_we_o(we_b), .exc_code_o(code_b),
        .exc_epc_o(epc_b), .exc_bd_o(bd_b), .eret_o(eret_b), .exc_cnt_o(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_left[i] = 0; m_pc[i] = 0; m_we[i] = 0; m_eret[i] = 0;
            m_code[i] = 0; m_epc[i] = 0; m_bd[i] = 0; m_cnt[i] = 0;
        end
    endtask

    // Predicts the outputs after the coming rising edge from the present inputs.
    task automatic model_edge();
        logic [31:0] st, ca, ep;
        logic        ip;
        logic [4:0]  code;
        bit          exc;
        st = (wb_we && wb_addr == 5'd12) ? wb_wd : status;
        ep = (wb_we && wb_addr == 5'd14) ? wb_wd : epc;
        ca = cause;
        if (wb_we && wb_addr == 5'd13) ca[9:8] = wb_wd[9:8];
        ip = st[0] && !st[1] && ((ca[15:8] & st[15:8]) != 8'd0);
        exc  = 1'b1;
        code = 5'd0;
        if (ip)            code = 5'd0;
        else if (flags[0]) code = 5'd8;
        else if (flags[1]) code = 5'd10;
        else if (flags[2]) code = 5'd12;
        else if (flags[3]) code = 5'd13;
        else               exc  = 1'b0;
        for (int i = 0; i < NI; i++) begin
            m_we[i]   = 1'b0;
            m_eret[i] = 1'b0;
            if (m_left[i] > 0) begin
                m_left[i]--;
            end else if (mem_valid && (exc || flags[4])) begin
                m_left[i] = FC[i];
                m_cnt[i]  = (m_cnt[i] + 1) % (1 << CW[i]);
                if (exc) begin
                    m_we[i]   = 1'b1;
                    m_pc[i]   = VEC;
                    m_code[i] = code;
                    m_epc[i]  = dslot ? mem_pc - 32'd4 : mem_pc;
                    m_bd[i]   = dslot;
                end else begin
                    m_eret[i] = 1'b1;
                    m_pc[i]   = ep;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("a.flush", 32'(flush_a), 32'(m_left[0] > 0));
        check("a.new_pc", pc_a, m_pc[0]);
        check("a.exc_we", 32'(we_a), 32'(m_we[0]));
        check("a.eret", 32'(eret_a), 32'(m_eret[0]));
        check("a.code", 32'(code_a), 32'(m_code[0]));
        check("a.epc", epc_a, m_epc[0]);
        check("a.bd", 32'(bd_a), 32'(m_bd[0]));
        check("a.cnt", 32'(cnt_a), 32'(m_cnt[0]));
        check("b.flush", 32'(flush_b), 32'(m_left[1] > 0));
        check("b.new_pc", pc_b, m_pc[1]);
        check("b.exc_we", 32'(we_b), 32'(m_we[1]));
        check("b.eret", 32'(eret_b), 32'(m_eret[1]));
        check("b.code", 32'(code_b), 32'(m_code[1]));
        check("b.epc", epc_b, m_epc[1]);
        check("b.bd", 32'(bd_b), 32'(m_bd[1]));
        check("b.cnt", 32'(cnt_b), 32'(m_cnt[1]));
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic step();
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_in(input logic v, input logic [31:0] pc, input logic ds,
                          input logic [4:0] fl, input logic [31:0] st,
                          input logic [31:0] ca, input logic [31:0] ep,
                          input logic we, input logic [4:0] wa, input logic [31:0] wd);
        mem_valid = v; mem_pc = pc; dslot = ds; flags = fl;
        status = st; cause = ca; epc = ep;
        wb_we = we; wb_addr = wa; wb_wd = wd;
    endtask

    task automatic idle(input int n);
        set_in(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic rand_inputs();
        logic [31:0] r, st, ca;
        int          sel;
        r   = $urandom();
        sel = $urandom_range(0, 7);
        mem_valid = ($urandom_range(0, 3) != 0);
        mem_pc    = $urandom();
        dslot     = r[0];
        if (sel < 3) flags = 5'd0;
        else flags = 5'(1 << $urandom_range(0, 4)) | ((sel == 7) ? r[8:4] : 5'd0);
        st = $urandom();
        st[0] = ($urandom_range(0, 3) != 0);
        st[1] = ($urandom_range(0, 3) == 0);
        status = st;
        ca = $urandom();
        if (r[1]) ca[15:8] = 8'd0;
        cause = ca;
        epc   = $urandom();
        wb_we = r[2];
        case ($urandom_range(0, 3))
            0: wb_addr = 5'd12;
            1: wb_addr = 5'd13;
            2: wb_addr = 5'd14;
            default: wb_addr = 5'($urandom_range(0, 31));
        endcase
        wb_wd = $urandom();
        if (r[3]) wb_wd[15:8] = 8'd0;
    endtask

    initial begin
        int fl_cnt, we_cnt;
        rst = 1'b1;
        set_in(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #1 rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst = 1'b1;
        idle(1);

        // syscall, no delay slot
        set_in(1'b1, 32'h00400010, 1'b0, 5'b00001, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        step();
        check("t1.flush", 32'(flush_a), 32'd1);
        check("t1.new_pc", pc_a, 32'h20);
        check("t1.we", 32'(we_a), 32'd1);
        check("t1.code", 32'(code_a), 32'd8);
        check("t1.epc", epc_a, 32'h00400010);
        check("t1.bd", 32'(bd_a), 32'd0);
        idle(1);
        check("t1.flush_off", 32'(flush_a), 32'd0);
        idle(3);

        // overflow in delay slot
        set_in(1'b1, 32'h00400104, 1'b1, 5'b00100, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        step();
        check("t2.code", 32'(code_b), 32'd12);
        check("t2.epc", epc_b, 32'h00400100);
        check("t2.bd", 32'(bd_b), 32'd1);
        idle(4);

        // interrupt beats syscall; then no valid instruction
        set_in(1'b1, 32'h00400200, 1'b0, 5'b00001, 32'h0000FF01, 32'h00000400, 32'd0, 1'b0, 5'd0, 32'd0);
        step();
        check("t3.code", 32'(code_a), 32'd0);
        check("t3.we", 32'(we_a), 32'd1);
        idle(4);
        set_in(1'b0, 32'h00400200, 1'b0, 5'b00001, 32'h0000FF01, 32'h00000400, 32'd0, 1'b0, 5'd0, 32'd0);
        step();
        check("t3.noflush", 32'(flush_a), 32'd0);
        idle(1);

        // WB clears IE / sets EXL alongside a pending interrupt
        set_in(1'b1, 32'h00400300, 1'b0, 5'd0, 32'h0000FF01, 32'h00000400, 32'd0, 1'b1, 5'd12, 32'h0000FF00);
        step();
        check("t4.ie_clr", 32'(flush_a), 32'd0);
        set_in(1'b1, 32'h00400300, 1'b0, 5'd0, 32'h0000FF01, 32'h00000400, 32'd0, 1'b1, 5'd12, 32'h0000FF03);
        step();
        check("t4.exl_set", 32'(flush_a), 32'd0);
        idle(1);

        // ERET with WB write to EPC
        set_in(1'b1, 32'h00400400, 1'b0, 5'b10000, 32'd0, 32'd0, 32'h100, 1'b1, 5'd14, 32'h200);
        step();
        check("t5.new_pc", pc_a, 32'h200);
        check("t5.eret", 32'(eret_a), 32'd1);
        check("t5.we", 32'(we_a), 32'd0);
        idle(1);
        check("t5.eret_off", 32'(eret_a), 32'd0);
        idle(3);

        // ERET with trap: exception wins
        set_in(1'b1, 32'h00400500, 1'b0, 5'b11000, 32'd0, 32'd0, 32'h100, 1'b0, 5'd0, 32'd0);
        step();
        check("t6.eret", 32'(eret_b), 32'd0);
        check("t6.code", 32'(code_b), 32'd13);
        idle(4);

        // fresh reset, then held trap against the 3-cycle flush
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        fl_cnt = 0;
        we_cnt = 0;
        set_in(1'b1, 32'h00400600, 1'b0, 5'b01000, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            fl_cnt += int'(flush_b);
            we_cnt += int'(we_b);
        end
        check("t7.flush_len", 32'(fl_cnt), 32'd3);
        check("t7.we_pulses", 32'(we_cnt), 32'd1);
        step();
        check("t7.cnt2", 32'(cnt_b), 32'd2);

        // asynchronous reset in the middle of the flush
        #2 rst = 1'b0;
        #1 model_reset();
        compare_all();
        @(negedge clk);
        compare_all();
        @(negedge clk);
        rst = 1'b1;
        idle(5);

        // random phase; CNT_W=4 on dut_b exercises counter wrap
        for (int k = 0; k < 600; k++) begin
            rand_inputs();
            step();
        end

        // burst of syscalls to force the counter over the wrap point
        for (int k = 0; k < 20; k++) begin
            set_in(1'b1, $urandom(), 1'b0, 5'b00001, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
